// File: rtl/wb_timer_pkg.sv
// Shared register offsets, CTRL bit positions and the byte-lane merge helper
// for the Wishbone timer.
package wb_timer_pkg;

  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_STATUS   = 3'd1;
  localparam logic [2:0] TMR_COUNT    = 3'd2;
  localparam logic [2:0] TMR_COMPARE  = 3'd3;
  localparam logic [2:0] TMR_PRESCALE = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  // Replace only the bytes whose lane enable is set.
  function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every
// PRESCALE+1 cycles; a clear zeroes the count and swallows that cycle's tick.
module wb_timer_prescaler
  import wb_timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic                  w_wrap;

  assign w_wrap = (r_pre_cnt == i_prescale);
  assign o_tick = i_en & w_wrap & ~i_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_pre_cnt <= '0;
    else if (i_clr)  r_pre_cnt <= '0;
    else if (i_en)   r_pre_cnt <= w_wrap ? '0 : r_pre_cnt + PRESCALE_W'(1);
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone B3 classic timer: free-running COUNT with prescaler, COMPARE match
// setting a sticky PEND, and a level interrupt PEND & IRQ_EN.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int          PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  logic [2:0]            r_ctrl;
  logic                  r_pend;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_ack;
  logic [31:0]           r_dat;

  logic        w_acc, w_wr;
  logic [2:0]  w_reg;
  logic        w_wr_ctrl, w_wr_status, w_wr_count, w_wr_cmp, w_wr_pre;
  logic        w_tick, w_match;
  logic [31:0] w_rdata;
  logic        w_unused_adr;

  assign w_unused_adr = ^wb_adr_i[1:0];

  // The access cycle is the one that raises ack; ack itself blocks a repeat.
  assign w_acc       = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr        = w_acc & wb_we_i;
  assign w_reg       = wb_adr_i[4:2];
  assign w_wr_ctrl   = w_wr && (w_reg == TMR_CTRL);
  assign w_wr_status = w_wr && (w_reg == TMR_STATUS);
  assign w_wr_count  = w_wr && (w_reg == TMR_COUNT);
  assign w_wr_cmp    = w_wr && (w_reg == TMR_COMPARE);
  assign w_wr_pre    = w_wr && (w_reg == TMR_PRESCALE);

  wb_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_en       (r_ctrl[CTRL_EN]),
    .i_clr      (w_wr_pre),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );

  // A COMPARE write in the same cycle invalidates the comparison.
  assign w_match = w_tick & (r_count == r_compare) & ~w_wr_cmp;

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      TMR_CTRL:     w_rdata = {29'd0, r_ctrl};
      TMR_STATUS:   w_rdata = {31'd0, r_pend};
      TMR_COUNT:    w_rdata = r_count;
      TMR_COMPARE:  w_rdata = r_compare;
      TMR_PRESCALE: w_rdata = 32'(r_prescale);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ctrl     <= '0;
      r_pend     <= 1'b0;
      r_count    <= '0;
      r_compare  <= RESET_COMPARE;
      r_prescale <= '0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : '0;
      if (w_wr_ctrl && wb_sel_i[0]) r_ctrl <= wb_dat_i[2:0];
      if (w_wr_pre)
        r_prescale <= PRESCALE_W'(sel_merge(32'(r_prescale), wb_dat_i, wb_sel_i));
      if (w_wr_cmp) r_compare <= sel_merge(r_compare, wb_dat_i, wb_sel_i);
      if (w_wr_count)
        r_count <= sel_merge(r_count, wb_dat_i, wb_sel_i);
      else if (w_tick)
        r_count <= (w_match && r_ctrl[CTRL_AUTO_RELOAD]) ? '0 : r_count + 32'd1;
      // Match set wins over both clear sources.
      if (w_match)
        r_pend <= 1'b1;
      else if (w_wr_cmp || (w_wr_status && wb_sel_i[0] && wb_dat_i[0]))
        r_pend <= 1'b0;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_pend & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: vector table, directed corner sequences and random
// bus traffic checked against an arithmetic reference model.
module tb_wb_timer;

  localparam int PW = 16;
  localparam logic [4:0] A_CTRL = 5'h00, A_STAT = 5'h04, A_CNT = 5'h08,
                         A_CMP = 5'h0C, A_PRE = 5'h10;

  logic        clk = 1'b0;
  logic        rst, we, cyc, stb;
  logic [4:0]  adr;
  logic [31:0] dat, dout;
  logic [3:0]  sel;
  logic        ack, irq;

  int tests = 0, fails = 0;
  bit mon_en = 0;

  always #5 clk = ~clk;

  wb_timer #(.PRESCALE_W(PW), .RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dout), .wb_ack_o(ack), .irq_o(irq)
  );

  // ---------------- reference model ----------------
  // Prescaler modelled as "enabled cycles since last clear" modulo PRESCALE+1.
  logic [2:0]      m_ctrl;
  logic            m_pend, m_ack;
  logic [31:0]     m_count, m_cmp, m_rdat, m_rsel;
  logic [PW-1:0]   m_pre;
  int unsigned     m_phase;
  logic            m_acc, m_wr, m_prew, m_cmpw, m_tick, m_match, m_irq;
  logic [2:0]      m_reg;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  assign m_reg   = adr[4:2];
  assign m_acc   = cyc & stb & ~m_ack;
  assign m_wr    = m_acc & we;
  assign m_prew  = m_wr && (m_reg == 3'd4);
  assign m_cmpw  = m_wr && (m_reg == 3'd3);
  assign m_tick  = m_ctrl[0] && !m_prew &&
                   ((m_phase % (32'(m_pre) + 32'd1)) == 32'(m_pre));
  assign m_match = m_tick && (m_count == m_cmp) && !m_cmpw;
  assign m_irq   = m_pend & m_ctrl[1];

  always_comb begin
    m_rsel = 32'd0;
    case (m_reg)
      3'd0: m_rsel = {29'd0, m_ctrl};
      3'd1: m_rsel = {31'd0, m_pend};
      3'd2: m_rsel = m_count;
      3'd3: m_rsel = m_cmp;
      3'd4: m_rsel = 32'(m_pre);
      default: m_rsel = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ctrl <= 3'd0; m_pend <= 1'b0; m_count <= 32'd0; m_cmp <= 32'hFFFF_FFFF;
      m_pre <= '0; m_phase <= 0; m_ack <= 1'b0; m_rdat <= 32'd0;
    end else begin
      m_ack  <= m_acc;
      m_rdat <= m_acc ? m_rsel : 32'd0;
      if (m_prew) m_phase <= 0;
      else if (m_ctrl[0]) m_phase <= m_phase + 1;
      if (m_wr && m_reg == 3'd0 && sel[0]) m_ctrl <= dat[2:0];
      if (m_prew) m_pre <= PW'(merge(32'(m_pre), dat, sel));
      if (m_cmpw) m_cmp <= merge(m_cmp, dat, sel);
      if (m_wr && m_reg == 3'd2) m_count <= merge(m_count, dat, sel);
      else if (m_tick) m_count <= (m_match && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
      if (m_match) m_pend <= 1'b1;
      else if (m_cmpw) m_pend <= 1'b0;
      else if (m_wr && m_reg == 3'd1 && sel[0] && dat[0]) m_pend <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("irq_vs_model", 32'(irq), 32'(m_irq));
      chk("ack_vs_model", 32'(ack), 32'(m_ack));
    end
  end

  // One access; called on a negedge, returns on a negedge two cycles later.
  task automatic bus(input bit w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    chk("ack_rise", 32'(ack), 32'd1);
    chk("dat_vs_model", dout, m_rdat);
    rd = dout;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_fall", 32'(ack), 32'd0);
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] x;
    bus(1'b1, a, d, 4'hF, x);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus(1'b0, a, 32'd0, 4'hF, v);
  endtask

  typedef struct {
    bit          we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[22];

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation did not finish, got hang, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v, v2;
    bit got;
    bit seen [3];

    vt[0]  = '{0, 5'h00, 0, 4'hF, 32'h0};
    vt[1]  = '{0, 5'h04, 0, 4'hF, 32'h0};
    vt[2]  = '{0, 5'h08, 0, 4'hF, 32'h0};
    vt[3]  = '{0, 5'h0F, 0, 4'hF, 32'hFFFF_FFFF};
    vt[4]  = '{0, 5'h10, 0, 4'hF, 32'h0};
    vt[5]  = '{0, 5'h14, 0, 4'hF, 32'h0};
    vt[6]  = '{0, 5'h18, 0, 4'hF, 32'h0};
    vt[7]  = '{0, 5'h1C, 0, 4'hF, 32'h0};
    vt[8]  = '{1, A_CNT, 32'hAABB_CCDD, 4'b0101, 0};
    vt[9]  = '{0, A_CNT, 0, 4'hF, 32'h00BB_00DD};
    vt[10] = '{1, A_CMP, 32'h1234_5678, 4'b0011, 0};
    vt[11] = '{0, A_CMP, 0, 4'hF, 32'hFFFF_5678};
    vt[12] = '{1, A_PRE, 32'h9ABC_DEF0, 4'b1110, 0};
    vt[13] = '{0, A_PRE, 0, 4'hF, 32'h0000_DE00};
    vt[14] = '{1, A_CTRL, 32'hFFFF_FFFE, 4'b0001, 0};
    vt[15] = '{0, A_CTRL, 0, 4'hF, 32'h6};
    vt[16] = '{1, 5'h18, 32'hFFFF_FFFF, 4'hF, 0};
    vt[17] = '{0, 5'h18, 0, 4'hF, 32'h0};
    vt[18] = '{1, A_CTRL, 32'hFF, 4'b1110, 0};
    vt[19] = '{0, A_CTRL, 0, 4'hF, 32'h6};
    vt[20] = '{1, A_CTRL, 32'h0, 4'hF, 0};
    vt[21] = '{1, A_PRE, 32'h0, 4'hF, 0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dout, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, v);
      if (!vt[i].we) chk($sformatf("vec%0d", i), v, vt[i].exp);
    end

    // Prescale 3: a tick every 4 cycles.
    wr(A_PRE, 3); wr(A_CNT, 0); wr(A_CTRL, 1);
    repeat (40) @(negedge clk);
    rd(A_CNT, v);
    tests++;
    if (v < 9 || v > 11) begin
      fails++; $display("FAIL presc_count: got %0d, expected 10 +/-1", v);
    end
    repeat (2) @(negedge clk);
    rd(A_CNT, v2);
    chk("presc_spacing", v2 - v, 32'd1);
    wr(A_CTRL, 0);

    // Compare match raises PEND/irq, W1C drops it.
    wr(A_PRE, 0); wr(A_CNT, 0); wr(A_STAT, 1); wr(A_CMP, 5); wr(A_CTRL, 3);
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (irq) got = 1;
    end
    chk("irq_rise", 32'(got), 32'd1);
    rd(A_CNT, v);
    chk("cnt_after_match", v, 32'd6);
    rd(A_STAT, v);
    chk("pend_set", v, 32'd1);
    wr(A_STAT, 1);
    chk("irq_after_w1c", 32'(irq), 32'd0);
    wr(A_CTRL, 0);

    // Auto reload: COUNT stays in 0..2.
    wr(A_CNT, 0); wr(A_STAT, 1); wr(A_CMP, 2); wr(A_PRE, 0); wr(A_CTRL, 7);
    seen = '{0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      rd(A_CNT, v);
      tests++;
      if (v > 2) begin fails++; $display("FAIL autoreload_range: got %0d, expected <=2", v); end
      else seen[v] = 1;
    end
    chk("autoreload_seen", {29'd0, seen[2], seen[1], seen[0]}, 32'd7);
    wr(A_CTRL, 0);

    // COUNT wraps silently.
    wr(A_PRE, 3); wr(A_CNT, 32'hFFFF_FFFF); wr(A_CMP, 5); wr(A_STAT, 1); wr(A_CTRL, 1);
    rd(A_CNT, v); rd(A_CNT, v);
    chk("wrap_before", v, 32'hFFFF_FFFF);
    rd(A_CNT, v);
    chk("wrap_to_zero", v, 32'd0);
    rd(A_STAT, v);
    chk("wrap_no_pend", v, 32'd0);
    wr(A_CTRL, 0);

    // Match on the same edge as W1C: PEND stays set.
    wr(A_PRE, 0); wr(A_CMP, 7); wr(A_CNT, 6); wr(A_STAT, 1); wr(A_CTRL, 3);
    wr(A_STAT, 1);
    chk("match_beats_w1c_irq", 32'(irq), 32'd1);
    rd(A_STAT, v);
    chk("match_beats_w1c", v, 32'd1);
    wr(A_CTRL, 0);

    // COMPARE write on the matching edge suppresses the match.
    wr(A_STAT, 1); wr(A_CMP, 7); wr(A_CNT, 6); wr(A_CTRL, 1);
    wr(A_CMP, 7);
    rd(A_STAT, v);
    chk("cmp_wr_suppress", v, 32'd0);
    wr(A_CTRL, 0);

    // COUNT write overrides a tick on the same edge; one more tick before read.
    wr(A_CNT, 32'h5000); wr(A_CMP, 32'hFFFF_0000); wr(A_CTRL, 1);
    wr(A_CNT, 100);
    rd(A_CNT, v);
    chk("cnt_wr_vs_tick", v, 32'd101);
    wr(A_CTRL, 0);

    // Reset while a strobe is pending: no ack, registers back to reset.
    wr(A_CTRL, 3); wr(A_STAT, 0);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CMP; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack1", 32'(ack), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_ack2", 32'(ack), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rd(vt[i].adr, v);
      chk($sformatf("post_rst%0d", i), v, vt[i].exp);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  r;
      logic [31:0] d;
      logic [3:0]  s;
      r = 3'($urandom_range(0, 7));
      case (r)
        3'd0: d = 32'($urandom_range(0, 7));
        3'd1: d = $urandom;
        3'd2: d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 12));
        3'd3: d = 32'($urandom_range(0, 12));
        3'd4: d = 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      bus($urandom_range(0, 1) == 1, {r, 2'($urandom_range(0, 3))}, d, s, v);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
